// File: rtl/note_record_controller.sv
// Sequencing controller between the key scanner and the tone generator. It passes live
// keys through, records (id, duration) events into a register memory, and replays them.
module note_record_controller #(
    parameter int TICK_CYCLES = 50000,
    parameter int DUR_W       = 12,
    parameter int DEPTH       = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [2:0]                   live_key_id,
    input  logic                         live_key_pressed,
    input  logic                         rec_start,
    input  logic                         play_start,
    input  logic                         stop,
    output logic [2:0]                   note_id,
    output logic                         note_active,
    output logic [1:0]                   state,
    output logic [$clog2(DEPTH):0]       event_count,
    output logic                         mem_full
);

    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_PLAY   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [2:0]           cur_id_q, cur_id_d;
    logic [DUR_W-1:0]     dur_q, dur_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic                 full_q, full_d;
    logic [ADDR_W-1:0]    ptr_q, ptr_d;
    logic [2:0]           note_q, note_d;

    logic [2:0]           mem_id  [DEPTH];
    logic [DUR_W-1:0]     mem_dur [DEPTH];

    logic                 tick;
    logic [DUR_W-1:0]     close_dur;
    logic                 wr_en;

    assign tick      = (state_q != S_IDLE) && (presc_q == PRESC_W'(TICK_CYCLES - 1));
    // In RECORD dur_q counts ticks of the open event; in PLAY it counts ticks elapsed in the entry.
    assign close_dur = dur_q + {{(DUR_W-1){1'b0}}, tick};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        presc_d  = tick ? '0 : presc_q + PRESC_W'(1);
        cur_id_d = cur_id_q;
        dur_d    = dur_q;
        count_d  = count_q;
        full_d   = full_q;
        ptr_d    = ptr_q;
        wr_en    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                presc_d = '0;
                dur_d   = '0;
                ptr_d   = '0;
                if (stop) begin
                    state_d = S_IDLE;
                end else if (rec_start) begin
                    state_d  = S_RECORD;
                    count_d  = '0;
                    full_d   = 1'b0;
                    cur_id_d = live_key_id;
                end else if (play_start && count_q != '0) begin
                    state_d = S_PLAY;
                end
            end

            S_RECORD: begin
                if (stop || live_key_id != cur_id_q || close_dur == {DUR_W{1'b1}}) begin
                    presc_d  = '0;
                    dur_d    = '0;
                    cur_id_d = live_key_id;
                    // Zero-length events are key-bounce glitches and are dropped.
                    wr_en    = (close_dur != '0);
                    if (wr_en) begin
                        count_d = count_q + (ADDR_W+1)'(1);
                        if (count_q + (ADDR_W+1)'(1) == (ADDR_W+1)'(DEPTH)) begin
                            full_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                    if (stop) state_d = S_IDLE;
                end else begin
                    dur_d = close_dur;
                end
            end

            S_PLAY: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (close_dur == mem_dur[ptr_q]) begin
                        dur_d = '0;
                        if ((ADDR_W+1)'(ptr_q) + (ADDR_W+1)'(1) == count_q) begin
                            state_d = S_IDLE;
                        end else begin
                            ptr_d = ptr_q + ADDR_W'(1);
                        end
                    end else begin
                        dur_d = close_dur;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        // A pressed live key always wins the single tone output.
        if (state_d == S_PLAY && !live_key_pressed) note_d = mem_id[ptr_d];
        else                                        note_d = live_key_id;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            cur_id_q <= '0;
            dur_q    <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ptr_q    <= '0;
            note_q   <= '0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            cur_id_q <= cur_id_d;
            dur_q    <= dur_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ptr_q    <= ptr_d;
            note_q   <= note_d;
        end
    end

    // NOTE: the event memory has no reset; event_count alone marks which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_id[count_q[ADDR_W-1:0]]  <= cur_id_q;
            mem_dur[count_q[ADDR_W-1:0]] <= close_dur;
        end
    end

    assign note_id     = note_q;
    assign note_active = (note_q != 3'd0);
    assign state       = state_q;
    assign event_count = count_q;
    assign mem_full    = full_q;

endmodule
